wh_output_arbiter: RTL and testbench

- Per-output-port allocator for the 5-port mesh switch. One instance sits on each output channel.
- Inputs are the matching oc_sel bit from every input port's XY router. It grants the output to one input using round-robin priority.
- The grant is held for the whole packet, wormhole style: it is taken at the head flit and released after the tail flit is accepted downstream.
- It drives the crossbar select and the per-input read/ack for the owning input.

---
 rtl/wh_output_arbiter_if.sv | 32 +++
 rtl/wh_output_arbiter.sv | 112 +++++++++++
 tb/tb_wh_output_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/wh_output_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wh_output_arbiter_if
// Description : Request/grant bundle between the input ports of one output
//               channel and its wormhole arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface wh_output_arbiter_if #(
    parameter int IN_N = 5,
    parameter int ID_W = 3
);
    logic [IN_N-1:0] req_i;
    logic [IN_N-1:0] last_i;
    logic            out_rdy_i;
    logic [IN_N-1:0] grant_o;
    logic [ID_W-1:0] grant_id_o;
    logic            valid_o;
    logic            busy_o;

    // Requesting side: input ports plus the downstream ready.
    modport master (
        output req_i, last_i, out_rdy_i,
        input  grant_o, grant_id_o, valid_o, busy_o
    );

    // Arbiter side.
    modport slave (
        input  req_i, last_i, out_rdy_i,
        output grant_o, grant_id_o, valid_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/wh_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wh_output_arbiter
// Description : Round-robin wormhole allocator for one mesh output channel.
//               Optional macro ARB_BACK2BACK_EN re-arbitrates on the release
//               cycle so consecutive packets need no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module wh_output_arbiter #(
    parameter int IN_N = 5,
    parameter int ID_W = 3
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    wh_output_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [IN_N-1:0] r_grant;
    logic [ID_W-1:0] r_grant_id;

    logic            w_owner_req;
    logic            w_owner_last;
    logic            w_valid;
    logic            w_release;
    logic            w_any;
    logic [ID_W-1:0] w_next_ptr;
    logic [ID_W-1:0] w_search_ptr;
    logic [IN_N-1:0] w_rot;
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_winner;
    logic [IN_N-1:0] w_winner_oh;

    // r_grant is one-hot, so masking avoids a variable bit-select.
    always_comb begin
        w_owner_req  = |(bus.req_i & r_grant);
        w_owner_last = |(bus.last_i & r_grant);
        w_valid      = (r_state == ST_LOCKED) & w_owner_req & bus.out_rdy_i;
        w_release    = w_valid & w_owner_last;
        w_any        = |bus.req_i;
        w_next_ptr   = (r_grant_id == ID_W'(IN_N - 1)) ? '0 : r_grant_id + 1'b1;
    end

    // In LOCKED the search starts just past the owner, which is what the
    // back-to-back path needs on the release cycle.
    always_comb begin
        w_search_ptr = (r_state == ST_LOCKED) ? w_next_ptr : r_ptr;
        w_rot        = IN_N'({bus.req_i, bus.req_i} >> w_search_ptr);
        w_sum        = '0;
        for (int i = IN_N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_sum = {1'b0, w_search_ptr} + (ID_W + 1)'(i);
            end
        end
        w_winner    = (w_sum >= (ID_W + 1)'(IN_N)) ? ID_W'(w_sum - (ID_W + 1)'(IN_N))
                                                   : w_sum[ID_W-1:0];
        w_winner_oh = IN_N'(1) << w_winner;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state    <= ST_LOCKED;
                        r_grant    <= w_winner_oh;
                        r_grant_id <= w_winner;
                    end
                end
                ST_LOCKED: begin
                    if (w_release) begin
                        r_ptr <= w_next_ptr;
`ifdef ARB_BACK2BACK_EN
                        if (w_any) begin
                            r_grant    <= w_winner_oh;
                            r_grant_id <= w_winner;
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                        end
`else
                        r_state <= ST_IDLE;
                        r_grant <= '0;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign bus.grant_o    = r_grant;
    assign bus.grant_id_o = r_grant_id;
    assign bus.valid_o    = w_valid;
    assign bus.busy_o     = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_wh_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wh_output_arbiter
// Description : Self-checking bench: vector table, directed corner cases and
//               randomized traffic against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wh_output_arbiter;

    localparam int N = 5;
`ifdef ARB_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    wh_output_arbiter_if #(.IN_N(N), .ID_W(3)) bus ();

    wh_output_arbiter #(.IN_N(N), .ID_W(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] req;
        logic [4:0] last;
        logic       rdy;
        logic [4:0] grant;
        logic [2:0] id;
        logic       valid;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    // Reference model: owner (-1 when free), rotating pointer, last crossbar id.
    int m_owner;
    int m_ptr;
    int m_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [4:0] g, input logic [2:0] id,
                             input logic v, input logic b);
        check({tag, ".grant"}, 32'(bus.grant_o), 32'(g));
        check({tag, ".id"},    32'(bus.grant_id_o), 32'(id));
        check({tag, ".valid"}, 32'(bus.valid_o), 32'(v));
        check({tag, ".busy"},  32'(bus.busy_o), 32'(b));
    endtask

    task automatic apply(input logic [4:0] r, input logic [4:0] l, input logic rd);
        bus.req_i     = r;
        bus.last_i    = l;
        bus.out_rdy_i = rd;
        @(negedge clk);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst           = 1'b1;
        bus.req_i     = '0;
        bus.last_i    = '0;
        bus.out_rdy_i = 1'b1;
        @(negedge clk);
        check_all("reset", 5'b0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        m_id    = 0;
    endtask

    function automatic int arb(input logic [4:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic fill_table;
`ifdef ARB_BACK2BACK_EN
        tbl.push_back('{5'b00011, 5'b00011, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{5'b00011, 5'b00011, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1});
        tbl.push_back('{5'b00011, 5'b00011, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1});
        tbl.push_back('{5'b00011, 5'b00011, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1});
        tbl.push_back('{5'b00011, 5'b00011, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1});
        tbl.push_back('{5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1});
        tbl.push_back('{5'b00000, 5'b00000, 1'b1, 5'b00001, 3'd0, 1'b0, 1'b1});
`else
        tbl.push_back('{5'b00100, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{5'b00100, 5'b00000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1});
        tbl.push_back('{5'b00100, 5'b00000, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1});
        tbl.push_back('{5'b00100, 5'b00100, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1});
        tbl.push_back('{5'b00010, 5'b00000, 1'b1, 5'b00000, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{5'b00010, 5'b00000, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1});
        tbl.push_back('{5'b00010, 5'b00000, 1'b0, 5'b00010, 3'd1, 1'b0, 1'b1});
        tbl.push_back('{5'b00010, 5'b00000, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1});
        tbl.push_back('{5'b00000, 5'b00000, 1'b1, 5'b00010, 3'd1, 1'b0, 1'b1});
        tbl.push_back('{5'b00010, 5'b00000, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1});
        tbl.push_back('{5'b00010, 5'b00010, 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1});
        tbl.push_back('{5'b11111, 5'b00000, 1'b1, 5'b00000, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{5'b11111, 5'b00100, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b1});
        tbl.push_back('{5'b11111, 5'b00000, 1'b1, 5'b00000, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{5'b01001, 5'b01000, 1'b0, 5'b01000, 3'd3, 1'b0, 1'b1});
        tbl.push_back('{5'b00001, 5'b00000, 1'b1, 5'b01000, 3'd3, 1'b0, 1'b1});
        tbl.push_back('{5'b01001, 5'b01000, 1'b1, 5'b01000, 3'd3, 1'b1, 1'b1});
        tbl.push_back('{5'b00001, 5'b00000, 1'b1, 5'b00000, 3'd3, 1'b0, 1'b0});
        tbl.push_back('{5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd0, 1'b1, 1'b1});
        tbl.push_back('{5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0});
`endif
    endtask

    initial begin
        bus.req_i     = '0;
        bus.last_i    = '0;
        bus.out_rdy_i = 1'b1;
        m_owner = -1;
        m_ptr   = 0;
        m_id    = 0;

        // Vector table
        fill_table();
        do_reset();
        foreach (tbl[i]) begin
            apply(tbl[i].req, tbl[i].last, tbl[i].rdy);
            check_all($sformatf("tbl%0d", i), tbl[i].grant, tbl[i].id, tbl[i].valid, tbl[i].busy);
            next_cycle();
        end

        // All inputs requesting, 2-flit packets: strict rotation 0..4,0
        do_reset();
        for (int p = 0; p < 6; p++) begin
            if (p == 0 || !B2B) begin
                apply(5'b11111, 5'b00000, 1'b1);
                check($sformatf("rr%0d.gap_busy", p), 32'(bus.busy_o), 32'd0);
                next_cycle();
            end
            apply(5'b11111, 5'b00000, 1'b1);
            check_all($sformatf("rr%0d.f1", p), 5'(1 << (p % N)), 3'(p % N), 1'b1, 1'b1);
            next_cycle();
            apply(5'b11111, 5'b11111, 1'b1);
            check_all($sformatf("rr%0d.f2", p), 5'(1 << (p % N)), 3'(p % N), 1'b1, 1'b1);
            next_cycle();
        end

        // Asynchronous reset mid-packet with owner 4
        do_reset();
        apply(5'b10000, 5'b00000, 1'b1);
        next_cycle();
        apply(5'b10000, 5'b00000, 1'b1);
        check_all("arst.pre", 5'b10000, 3'd4, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst.grant", 32'(bus.grant_o), 32'd0);
        check("arst.busy",  32'(bus.busy_o),  32'd0);
        check("arst.valid", 32'(bus.valid_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(5'b10001, 5'b00000, 1'b1);
        check_all("arst.idle", 5'b00000, 3'd0, 1'b0, 1'b0);
        next_cycle();
        apply(5'b10001, 5'b00000, 1'b1);
        check_all("arst.regrant", 5'b00001, 3'd0, 1'b1, 1'b1);
        next_cycle();

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [4:0] r;
            logic [4:0] l;
            logic       rd;
            logic [4:0] eg;
            logic       ev;
            r  = (($urandom % 8) == 0) ? 5'b0 : 5'($urandom);
            l  = 5'($urandom & $urandom);
            rd = (($urandom % 4) != 0);
            eg = (m_owner >= 0) ? 5'(1 << m_owner) : 5'b0;
            ev = (m_owner >= 0) && r[m_owner] && rd;
            apply(r, l, rd);
            check_all($sformatf("rnd%0d", c), eg, 3'(m_id), ev, (m_owner >= 0));
            if (m_owner < 0) begin
                if (r != 0) begin
                    m_owner = arb(r, m_ptr);
                    m_id    = m_owner;
                end
            end else if (ev && l[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                if (B2B && r != 0) begin
                    m_owner = arb(r, m_ptr);
                    m_id    = m_owner;
                end
            end
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
